decim_stream_packer: RTL
========================

DECIM_STREAM_PACKER -- requirements
Module: decim_stream_packer

Interface
REQ-001 Parameter: DATA_W, 32, sample width.
REQ-002 Parameter: FIFO_DEPTH, 16, buffered samples; power of two, >= 4.
REQ-003 Port: clk  in  1  single clock for all logic.
REQ-004 Port: reset_n  in  1  reset; asynchronous, active-low.
REQ-005 Port: data_in  in  DATA_W  decimated sample from the decimation filter.
REQ-006 Port: din_rdy  in  1  one-cycle strobe; data_in valid this cycle.
REQ-007 Port: enable  in  1  accept samples when high.
REQ-008 Port: frame_len  in  16  beats per output frame.
REQ-009 Port: ovf_clr  in  1  one-cycle pulse; clears overflow status.
REQ-010 Port: m_axis_tdata  out  DATA_W  output sample.
REQ-011 Port: m_axis_tvalid  out  1  AXI4-Stream valid.
REQ-012 Port: m_axis_tready  in  1  AXI4-Stream ready.
REQ-013 Port: m_axis_tlast  out  1  last beat of frame.
REQ-014 Port: fill_level  out  $clog2(FIFO_DEPTH)+1  samples held, FIFO plus output register.
REQ-015 Port: overflow  out  1  sticky; a sample was dropped.
REQ-016 Port: drop_count  out  16  dropped samples, saturating.

Function
REQ-017 Write: din_rdy && enable && !full pushes data_in; din_rdy while enable low is ignored, not counted.
REQ-018 Full is evaluated before any same-cycle pop; din_rdy && enable && full drops the sample even if a pop occurs that cycle.
REQ-019 Drop: sets overflow; drop_count +1, holding at 16'hFFFF.
REQ-020 ovf_clr clears overflow and drop_count; a drop in the same cycle wins: overflow=1, drop_count=1.
REQ-021 Pointers carry one extra wrap bit; full = addresses equal, wrap bits differ; empty = pointers equal.
REQ-022 Output register: a two-state FSM, OUT_EMPTY and OUT_VALID.
REQ-023 OUT_EMPTY -> OUT_VALID when the FIFO is non-empty; the head word loads into m_axis_tdata.
REQ-024 OUT_VALID && m_axis_tready with FIFO non-empty: reload the next word and stay in OUT_VALID; no bubble.
REQ-025 OUT_VALID && m_axis_tready with FIFO empty: go to OUT_EMPTY.
REQ-026 Latency: sample pushed at edge k into an empty block -> m_axis_tvalid=1 after edge k+1.
REQ-027 While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tlast stay stable.
REQ-028 Frame: a 16-bit beat counter counts accepted beats (tvalid && tready).
REQ-029 m_axis_tlast=1 when beat count == latched length - 1; the counter wraps to 0 on that beat.
REQ-030 frame_len latches on the first beat of each frame; a value of 0 or 1 gives tlast on every beat.
REQ-031 A frame_len change mid-frame takes effect at the next frame.
REQ-032 Throughput: one sample per cycle sustained with m_axis_tready held high.

Reset
REQ-033 Reset (reset_n low, asynchronous) sets m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, fill_level=0, overflow=0, drop_count=0.
REQ-034 Reset empties the FIFO pointers, beat counter and latched length, and puts the FSM in OUT_EMPTY.
REQ-035 Reset mid-frame discards buffered data; the next frame starts at beat 0.

Structure
REQ-036 Shared package decim_pkg: DATA_W default, FIFO_DEPTH default, drop-counter width, and the output FSM state enum.
REQ-037 One sub-module, decim_sync_fifo, holds storage, pointers and full/empty.
REQ-038 The output FSM, framing and status counters live in the top module.
REQ-039 FIFO storage has no reset; only pointers and flags are reset.

Verification
REQ-040 Back-to-back: 8 strobes 0x1..0x8, tready=1, frame_len=4 -> 8 beats in order; tlast on 0x4 and 0x8; first tvalid one cycle after the first push.
REQ-041 Backpressure: tready=0 for 20 strobes, FIFO_DEPTH=16 -> fill_level=17, overflow=1, drop_count=3; the first 17 samples drain in order.
REQ-042 Stall hold: tready toggled 1/0 each cycle -> tdata/tlast never change while tvalid && !tready; no loss or duplication.
REQ-043 Clear race: ovf_clr coincident with a drop when drop_count=5 -> overflow=1, drop_count=1.
REQ-044 Frame change: frame_len changed 4 -> 2 at beat 1 -> tlast on beat 3, then every 2nd beat.
REQ-045 Reset mid-stream: reset_n low with 6 words held -> tvalid=0, fill_level=0 at once; post-reset stream starts at beat 0.

Source files
------------

// File: rtl/decim_pkg.sv
// Shared definitions for the decimated-sample stream packer: default sizes,
// status counter widths and the output-stage state encoding.
package decim_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int DROP_CNT_W     = 16;
  localparam int FRAME_LEN_W    = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Saturating increment for the dropped-sample counter.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/decim_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the head word is visible
// combinationally on o_rd_data whenever o_empty is low.
module decim_sync_fifo
  import decim_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_do_wr;
  logic              w_do_rd;

  assign w_do_wr = i_wr_en && !o_full;
  assign w_do_rd = i_rd_en && !o_empty;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers need a known value, and a reset on the array blocks RAM mapping.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Same slot with opposite wrap bits means the writer has lapped the reader.
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/decim_stream_packer.sv
// Buffers decimated samples and emits them as framed AXI4-Stream beats,
// with sticky overflow and a saturating dropped-sample counter.
module decim_stream_packer
  import decim_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   din_rdy,
  input  logic                   enable,
  input  logic [FRAME_LEN_W-1:0] frame_len,
  input  logic                   ovf_clr,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [FILL_W-1:0]      fill_level,
  output logic                   overflow,
  output logic [DROP_CNT_W-1:0]  drop_count
);

  out_state_e             r_state;
  out_state_e             w_state_next;
  logic                   w_load;

  logic [DATA_W-1:0]      r_tdata;
  logic                   r_tlast;
  logic [FRAME_LEN_W-1:0] r_beat_cnt;
  logic [FRAME_LEN_W-1:0] r_len_lat;
  logic                   r_overflow;
  logic [DROP_CNT_W-1:0]  r_drop_count;

  logic [DATA_W-1:0]      w_fifo_rd_data;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [FILL_W-1:0]      w_fifo_count;

  logic                   w_write_req;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_beat_accept;
  logic [FRAME_LEN_W-1:0] w_beat_next;
  logic [FRAME_LEN_W-1:0] w_len_eff;
  logic                   w_tlast_next;

  // Full is the registered pre-pop value, so a same-cycle drain never rescues a sample.
  assign w_write_req = din_rdy && enable;
  assign w_push      = w_write_req && !w_fifo_full;
  assign w_drop      = w_write_req && w_fifo_full;

  decim_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (w_push),
    .i_wr_data (data_in),
    .i_rd_en   (w_load),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= OUT_EMPTY;
    else          r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: defaults come first so every path assigns both signals and no latch is inferred.
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      OUT_EMPTY: begin
        if (!w_fifo_empty) begin
          w_state_next = OUT_VALID;
          w_load       = 1'b1;
        end
      end
      OUT_VALID: begin
        if (m_axis_tready) begin
          if (!w_fifo_empty) w_load       = 1'b1;
          else               w_state_next = OUT_EMPTY;
        end
      end
      default: w_state_next = OUT_EMPTY;
    endcase
  end

  // Index of the beat that the next loaded word will carry; length is sampled
  // live only for beat 0, otherwise the value latched at the frame start is used.
  assign w_beat_accept = (r_state == OUT_VALID) && m_axis_tready;
  assign w_beat_next   = !w_beat_accept ? r_beat_cnt
                       : (r_tlast ? '0 : r_beat_cnt + FRAME_LEN_W'(1));
  assign w_len_eff     = (w_beat_next == '0) ? frame_len : r_len_lat;
  assign w_tlast_next  = (w_len_eff <= FRAME_LEN_W'(1))
                      || (w_beat_next == w_len_eff - FRAME_LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_beat_cnt <= '0;
      r_len_lat  <= '0;
    end else begin
      r_beat_cnt <= w_beat_next;
      if (w_load) begin
        r_tdata <= w_fifo_rd_data;
        r_tlast <= w_tlast_next;
        if (w_beat_next == '0) r_len_lat <= frame_len;
      end else if (w_state_next == OUT_EMPTY) begin
        r_tlast <= 1'b0;
      end
    end
  end

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow   <= 1'b1;
      r_drop_count <= ovf_clr ? DROP_CNT_W'(1) : sat_inc(r_drop_count);
    end else if (ovf_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign m_axis_tvalid = (r_state == OUT_VALID);
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign fill_level    = w_fifo_count + {{(FILL_W-1){1'b0}}, (r_state == OUT_VALID)};
  assign overflow      = r_overflow;
  assign drop_count    = r_drop_count;

endmodule
